// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the 1-to-8 stream demultiplexer.
package demux_pkg;

  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Per-output one-entry buffer occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_t sel);
    logic [NUM_OUT-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: holds a single beat until its consumer takes it.
module demux_slot #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] din,
  input  logic             ready,
  output logic             can_accept,
  output logic             valid,
  output logic [width-1:0] dout
);
  import demux_pkg::*;

  slot_state_t      state_q, state_d;
  logic [width-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load wins over a drain, which covers the fill-and-drain case.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = din;
    end else if ((state_q == SLOT_FULL) && ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // The valid output is the slot state itself.
  assign valid      = (state_q == SLOT_FULL);
  assign can_accept = (state_q == SLOT_EMPTY) || ready;
  assign dout       = data_q;

endmodule

// File: rtl/demux_1to8_stream.sv
// Registered 1-to-8 stream demultiplexer with unicast select and all-or-nothing broadcast.
//
// Handshakes: a beat transfers on any rising edge where valid and ready are
// both 1. s_ready never looks at s_valid, but does depend combinationally on
// q_ready, so the consumer ready path reaches the producer in the same cycle.
module demux_1to8_stream #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] s_data,
  input  logic [2:0]       s_sel,
  input  logic             s_bcast,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [width-1:0] q0,
  output logic [width-1:0] q1,
  output logic [width-1:0] q2,
  output logic [width-1:0] q3,
  output logic [width-1:0] q4,
  output logic [width-1:0] q5,
  output logic [width-1:0] q6,
  output logic [width-1:0] q7,
  output logic [7:0]       q_valid,
  input  logic [7:0]       q_ready
);
  import demux_pkg::*;

  logic [NUM_OUT-1:0] can;
  logic [NUM_OUT-1:0] tgt;
  logic [NUM_OUT-1:0] load;
  logic [width-1:0]   dout [NUM_OUT];

  always_comb begin
    tgt = sel_onehot(s_sel);
    if (s_bcast) begin
      tgt = '1;
    end
  end

  // Broadcast only proceeds when every slot can take it.
  always_comb begin
    s_ready = can[s_sel];
    if (s_bcast) begin
      s_ready = &can;
    end
  end

  assign load = tgt & {NUM_OUT{s_valid & s_ready}};

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(.width(width)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[i]),
      .din        (s_data),
      .ready      (q_ready[i]),
      .can_accept (can[i]),
      .valid      (q_valid[i]),
      .dout       (dout[i])
    );
  end

  assign q0 = dout[0];
  assign q1 = dout[1];
  assign q2 = dout[2];
  assign q3 = dout[3];
  assign q4 = dout[4];
  assign q5 = dout[5];
  assign q6 = dout[6];
  assign q7 = dout[7];

endmodule
